// File: rtl/mips_avalon_arbiter.sv
// Fixed-priority arbiter sharing the CPU Avalon-MM master between
// write-buffer drain, dcache refill and icache refill.
module mips_avalon_arbiter #(
  parameter int WB_MAX_STREAK = 4,
  parameter int STREAK_BITS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic        d_read,
  input  logic [31:0] d_addr,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  input  logic        wb_write,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_writedata,
  input  logic [3:0]  wb_byteenable,
  input  logic        wb_empty,
  output logic        wb_waitrequest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_WB,
    GNT_D,
    GNT_I
  } state_t;

  localparam logic [STREAK_BITS-1:0] STREAK_MAX =
    STREAK_BITS'(WB_MAX_STREAK);

  state_t state, state_nxt;
  logic [STREAK_BITS-1:0] streak;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic wb_ok, d_ok, i_ok;
  logic done;

  // dcache reads wait for an empty write buffer to keep RAW order
  always_comb begin
    d_ok  = d_read & wb_empty;
    i_ok  = i_read;
    wb_ok = wb_write &
            ~((streak == STREAK_MAX) & (i_read | d_ok));
    done  = (state != IDLE) & ~avm_waitrequest;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (wb_ok)     state_nxt = GNT_WB;
      else if (d_ok) state_nxt = GNT_D;
      else if (i_ok) state_nxt = GNT_I;
    end else if (done) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= '0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (state_nxt == GNT_WB) begin
          addr_q <= wb_addr;
          data_q <= wb_writedata;
          be_q   <= wb_byteenable;
        end else if (state_nxt == GNT_D) begin
          addr_q <= d_addr;
          data_q <= '0;
          be_q   <= 4'hF;
        end else if (state_nxt == GNT_I) begin
          addr_q <= i_addr;
          data_q <= '0;
          be_q   <= 4'hF;
        end
      end
      if (done) begin
        if ((state == GNT_WB) & (i_read | d_read)) begin
          if (streak != STREAK_MAX) streak <= streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;
  assign avm_read       = (state == GNT_D) | (state == GNT_I);
  assign avm_write      = (state == GNT_WB);

  assign wb_waitrequest = ~((state == GNT_WB) & ~avm_waitrequest);
  assign d_waitrequest  = ~((state == GNT_D) & ~avm_waitrequest);
  assign i_waitrequest  = ~((state == GNT_I) & ~avm_waitrequest);
  assign i_readdata     = avm_readdata;
  assign d_readdata     = avm_readdata;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter: reset, reads, priority,
// RAW blocking, write-buffer streak limit and stalled writes.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read;
  logic [31:0] d_addr;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        wb_write;
  logic [31:0] wb_addr;
  logic [31:0] wb_writedata;
  logic [3:0]  wb_byteenable;
  logic        wb_empty;
  logic        wb_waitrequest;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(
    .WB_MAX_STREAK(4),
    .STREAK_BITS(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_read         (i_read),
    .i_addr         (i_addr),
    .i_waitrequest  (i_waitrequest),
    .i_readdata     (i_readdata),
    .d_read         (d_read),
    .d_addr         (d_addr),
    .d_waitrequest  (d_waitrequest),
    .d_readdata     (d_readdata),
    .wb_write       (wb_write),
    .wb_addr        (wb_addr),
    .wb_writedata   (wb_writedata),
    .wb_byteenable  (wb_byteenable),
    .wb_empty       (wb_empty),
    .wb_waitrequest (wb_waitrequest),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_write} !== 2'b00) begin
      errors++;
      $display("FAIL rst_strobes got %b exp 00", {avm_read, avm_write});
    end
    checks++;
    if ({wb_waitrequest, d_waitrequest, i_waitrequest} !== 3'b111) begin
      errors++;
      $display("FAIL rst_wait got %b exp 111",
               {wb_waitrequest, d_waitrequest, i_waitrequest});
    end
    tick();
    rst = 1'b0;
    wb_write = 1'b1;
    wb_addr = 32'hAAAA_0000;
    wb_writedata = 32'h0000_0055;
    wb_byteenable = 4'hF;
    wb_empty = 1'b0;
    avm_waitrequest = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (avm_write !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_write got %b exp 1", avm_write);
    end
    tick();
    rst = 1'b1;
    wb_write = 1'b0;
    wb_empty = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_write} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_strobes got %b exp 00", {avm_read, avm_write});
    end
    checks++;
    if ({wb_waitrequest, d_waitrequest, i_waitrequest} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_wait got %b exp 111",
               {wb_waitrequest, d_waitrequest, i_waitrequest});
    end
    checks++;
    if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin
      errors++;
      $display("FAIL midrst_regs got %h %h %h exp 0 0 0",
               avm_address, avm_writedata, avm_byteenable);
    end
    checks++;
    if (dut.streak !== 3'd0) begin
      errors++;
      $display("FAIL midrst_streak got %0d exp 0", dut.streak);
    end
    tick();
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({wb_waitrequest, avm_write} !== 2'b10) begin
      errors++;
      $display("FAIL abandon got %b exp 10", {wb_waitrequest, avm_write});
    end
    tick();
  endtask

  task automatic test_single_read;
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    avm_waitrequest = 1'b1;
    avm_readdata = 32'h0;
    @(negedge clk);
    checks++;
    if (avm_read !== 1'b0) begin
      errors++;
      $display("FAIL rd_n got %b exp 0", avm_read);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_address, avm_byteenable, i_waitrequest} !==
        {1'b1, 32'h0000_1000, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL rd_n1 got %b %h %h %b exp 1 00001000 f 1",
               avm_read, avm_address, avm_byteenable, i_waitrequest);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_address, i_waitrequest} !==
        {1'b1, 32'h0000_1000, 1'b1}) begin
      errors++;
      $display("FAIL rd_stall got %b %h %b exp 1 00001000 1",
               avm_read, avm_address, i_waitrequest);
    end
    tick();
    avm_waitrequest = 1'b0;
    avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({i_waitrequest, d_waitrequest, wb_waitrequest} !== 3'b011) begin
      errors++;
      $display("FAIL rd_ack got %b exp 011",
               {i_waitrequest, d_waitrequest, wb_waitrequest});
    end
    checks++;
    if (i_readdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data got %h exp deadbeef", i_readdata);
    end
    tick();
    i_read = 1'b0;
    avm_readdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({avm_read, i_waitrequest} !== 2'b01) begin
      errors++;
      $display("FAIL rd_after got %b exp 01", {avm_read, i_waitrequest});
    end
  endtask

  task automatic test_priority;
    wb_write = 1'b1;
    wb_addr = 32'h0000_3000;
    wb_writedata = 32'hCAFE_0001;
    wb_byteenable = 4'b0101;
    wb_empty = 1'b0;
    d_read = 1'b1;
    d_addr = 32'h0000_4000;
    i_read = 1'b1;
    i_addr = 32'h0000_5000;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h1111_2222;
    tick();
    @(negedge clk);
    checks++;
    if ({avm_write, avm_read, wb_waitrequest, avm_address, avm_byteenable} !==
        {1'b1, 1'b0, 1'b0, 32'h0000_3000, 4'b0101}) begin
      errors++;
      $display("FAIL pri_wb1 got %b%b%b %h %h exp 100 00003000 5",
               avm_write, avm_read, wb_waitrequest,
               avm_address, avm_byteenable);
    end
    tick();
    wb_addr = 32'h0000_3004;
    @(negedge clk);
    checks++;
    if ({avm_write, avm_read} !== 2'b00) begin
      errors++;
      $display("FAIL pri_idle got %b exp 00", {avm_write, avm_read});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({avm_write, wb_waitrequest, avm_address} !==
        {1'b1, 1'b0, 32'h0000_3004}) begin
      errors++;
      $display("FAIL pri_wb2 got %b%b %h exp 10 00003004",
               avm_write, wb_waitrequest, avm_address);
    end
    tick();
    wb_write = 1'b0;
    wb_empty = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_address, avm_byteenable, d_waitrequest,
         i_waitrequest, d_readdata} !==
        {1'b1, 32'h0000_4000, 4'hF, 1'b0, 1'b1, 32'h1111_2222}) begin
      errors++;
      $display("FAIL pri_d got %b %h %h %b%b %h exp 1 00004000 f 01 11112222",
               avm_read, avm_address, avm_byteenable,
               d_waitrequest, i_waitrequest, d_readdata);
    end
    tick();
    d_read = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_address, avm_byteenable, i_waitrequest} !==
        {1'b1, 32'h0000_5000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL pri_i got %b %h %h %b exp 1 00005000 f 0",
               avm_read, avm_address, avm_byteenable, i_waitrequest);
    end
    tick();
    i_read = 1'b0;
  endtask

  task automatic test_raw_block;
    wb_empty = 1'b0;
    wb_write = 1'b0;
    d_read = 1'b1;
    d_addr = 32'h0000_6000;
    avm_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({avm_read, d_waitrequest} !== 2'b01) begin
        errors++;
        $display("FAIL raw_block%0d got %b exp 01",
                 k, {avm_read, d_waitrequest});
      end
    end
    tick();
    wb_empty = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({avm_read, avm_address, d_waitrequest} !==
        {1'b1, 32'h0000_6000, 1'b0}) begin
      errors++;
      $display("FAIL raw_grant got %b %h %b exp 1 00006000 0",
               avm_read, avm_address, d_waitrequest);
    end
    tick();
    d_read = 1'b0;
  endtask

  task automatic test_starvation;
    logic [1:0] exp_g [6];
    logic [1:0] got;
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    wb_write = 1'b1;
    wb_empty = 1'b0;
    wb_addr = 32'h0000_7000;
    i_read = 1'b1;
    i_addr = 32'h0000_8000;
    avm_waitrequest = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      case ({wb_waitrequest, d_waitrequest, i_waitrequest})
        3'b011:  got = 2'd0;
        3'b101:  got = 2'd1;
        3'b110:  got = 2'd2;
        default: got = 2'd3;
      endcase
      checks++;
      if (got !== exp_g[k]) begin
        errors++;
        $display("FAIL streak_seq%0d got %0d exp %0d", k, got, exp_g[k]);
      end
      tick();
      if (got == 2'd2) begin
        i_read = 1'b0;
        checks++;
        if (dut.streak !== 3'd0) begin
          errors++;
          $display("FAIL streak_clr got %0d exp 0", dut.streak);
        end
      end
    end
    wb_write = 1'b0;
    i_read = 1'b0;
  endtask

  task automatic test_write_path;
    wb_write = 1'b1;
    wb_empty = 1'b0;
    wb_addr = 32'h0000_2004;
    wb_writedata = 32'h1234_5678;
    wb_byteenable = 4'b0011;
    avm_waitrequest = 1'b1;
    tick();
    wb_addr = 32'hFFFF_FFFF;
    wb_writedata = 32'h0;
    wb_byteenable = 4'hC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({avm_write, avm_address, avm_writedata, avm_byteenable,
           wb_waitrequest} !==
          {1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b1}) begin
        errors++;
        $display("FAIL wr_stall%0d got %b %h %h %h %b exp 1 00002004 12345678 3 1",
                 k, avm_write, avm_address, avm_writedata,
                 avm_byteenable, wb_waitrequest);
      end
      tick();
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if ({avm_write, wb_waitrequest} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ack got %b exp 10", {avm_write, wb_waitrequest});
    end
    tick();
    wb_write = 1'b0;
    wb_empty = 1'b1;
    @(negedge clk);
    checks++;
    if ({avm_write, wb_waitrequest} !== 2'b01) begin
      errors++;
      $display("FAIL wr_after got %b exp 01", {avm_write, wb_waitrequest});
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0;
    i_addr = '0;
    d_read = 1'b0;
    d_addr = '0;
    wb_write = 1'b0;
    wb_addr = '0;
    wb_writedata = '0;
    wb_byteenable = '0;
    wb_empty = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    test_reset();
    test_single_read();
    test_priority();
    test_raw_block();
    test_starvation();
    test_write_path();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
